// File: rtl/vga_timing_engine.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_engine
// Purpose  : Parametrised raster timing generator. It produces two coordinate
//            streams. The fetch stream drives memory address generation. The
//            display stream drives the DAC/pins and trails the fetch stream by
//            exactly LEAD pixel ticks. It also produces sync, line/frame/screen
//            strobes and a frame counter.
// Ports    : clk25       - video clock
//            reset       - synchronous, active-high
//            pixEn       - pixel tick qualifier (tie high for 1 pixel/clk)
//            fetchActive - fetch position inside the visible area
//            fetchX/Y    - fetch coordinates, 0 outside the visible area
//            active      - display position inside the visible area
//            x/y         - display coordinates, 0 outside the visible area
//            hSync/vSync - sync outputs at H_POL/V_POL polarity
//            lineStart   - strobe, display reached hPos=0
//            frameStart  - strobe, display reached (0,0)
//            screenEnd   - strobe, display reached (H_TOTAL-1, V_TOTAL-1)
//            frameCount  - completed frames, wraps modulo 2^16
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_engine #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0,
  parameter int LEAD     = 2,
  parameter int XW       = 10,
  parameter int YW       = 10
) (
  input  logic          clk25,
  input  logic          reset,
  input  logic          pixEn,
  output logic          fetchActive,
  output logic [XW-1:0] fetchX,
  output logic [YW-1:0] fetchY,
  output logic          active,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          hSync,
  output logic          vSync,
  output logic          lineStart,
  output logic          frameStart,
  output logic          screenEnd,
  output logic [15:0]   frameCount
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Comparisons run one bit wider than the counters so that a sync window
  // ending exactly at H_TOTAL (zero back porch) with H_TOTAL = 2^XW still fits.
  localparam logic [XW:0] c_H_ACT    = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0] c_H_SYNC_S = (XW+1)'(H_ACTIVE + H_FP);
  localparam logic [XW:0] c_H_SYNC_E = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [XW:0] c_H_LAST   = (XW+1)'(c_H_TOTAL - 1);
  localparam logic [YW:0] c_V_ACT    = (YW+1)'(V_ACTIVE);
  localparam logic [YW:0] c_V_SYNC_S = (YW+1)'(V_ACTIVE + V_FP);
  localparam logic [YW:0] c_V_SYNC_E = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [YW:0] c_V_LAST   = (YW+1)'(c_V_TOTAL - 1);

  localparam logic c_H_POL = (H_POL != 0);
  localparam logic c_V_POL = (V_POL != 0);

  // Per-stage payload carried down the fetch-to-display chain.
  typedef struct packed {
    logic          active;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          hWin;
    logic          vWin;
    logic          isLineStart;
    logic          isFrameStart;
    logic          isEnd;
  } stage_t;

  // --------------------------------------------------------------------------
  // Raster counters
  // --------------------------------------------------------------------------
  logic [XW-1:0] r_hPos;
  logic [YW-1:0] r_vPos;
  logic          w_hLast;
  logic          w_vLast;

  assign w_hLast = ({1'b0, r_hPos} == c_H_LAST);
  assign w_vLast = ({1'b0, r_vPos} == c_V_LAST);

  always_ff @(posedge clk25) begin
    if (reset) begin
      r_hPos <= '0;
      r_vPos <= '0;
    end else if (pixEn) begin
      if (w_hLast) begin
        r_hPos <= '0;
        // Vertical wrap shares the tick of the last horizontal wrap.
        if (w_vLast) begin
          r_vPos <= '0;
        end else begin
          r_vPos <= r_vPos + 1'b1;
        end
      end else begin
        r_hPos <= r_hPos + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Decode of the current raster position into a stage payload
  // --------------------------------------------------------------------------
  logic   w_hVis;
  logic   w_vVis;
  stage_t w_rasterPix;

  assign w_hVis = ({1'b0, r_hPos} < c_H_ACT);
  assign w_vVis = ({1'b0, r_vPos} < c_V_ACT);

  always_comb begin
    w_rasterPix              = '0;
    w_rasterPix.active       = w_hVis & w_vVis;
    // Coordinates are only meaningful inside the visible area.
    w_rasterPix.x            = (w_hVis & w_vVis) ? r_hPos : '0;
    w_rasterPix.y            = (w_hVis & w_vVis) ? r_vPos : '0;
    w_rasterPix.hWin         = ({1'b0, r_hPos} >= c_H_SYNC_S) &&
                               ({1'b0, r_hPos} <  c_H_SYNC_E);
    w_rasterPix.vWin         = ({1'b0, r_vPos} >= c_V_SYNC_S) &&
                               ({1'b0, r_vPos} <  c_V_SYNC_E);
    w_rasterPix.isLineStart  = (r_hPos == '0);
    w_rasterPix.isFrameStart = (r_hPos == '0) && (r_vPos == '0);
    w_rasterPix.isEnd        = w_hLast & w_vLast;
  end

  // --------------------------------------------------------------------------
  // Pipeline: stage 0 is the fetch stage, stage LEAD is the display stage.
  // With LEAD=0 both roles fall on the same register.
  // --------------------------------------------------------------------------
  stage_t r_stage [0:LEAD];
  stage_t w_dispIn;   // value the display stage captures on the next tick

  generate
    if (LEAD == 0) begin : g_noLead
      assign w_dispIn = w_rasterPix;
    end else begin : g_lead
      assign w_dispIn = r_stage[LEAD-1];
    end
  endgenerate

  always_ff @(posedge clk25) begin
    if (reset) begin
      for (int i = 0; i <= LEAD; i++) begin
        r_stage[i] <= '0;
      end
    end else if (pixEn) begin
      r_stage[0] <= w_rasterPix;
      for (int i = 1; i <= LEAD; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Strobe qualifier and frame counter
  // --------------------------------------------------------------------------
  // r_pixTick marks the single cycle after a display-stage load. Held cycles
  // and the zeroed payload during pipeline fill both keep the strobes low.
  logic        r_pixTick;
  logic [15:0] r_frameCount;

  always_ff @(posedge clk25) begin
    if (reset) begin
      r_pixTick    <= 1'b0;
      r_frameCount <= '0;
    end else begin
      r_pixTick <= pixEn;
      // Increment on the edge that loads the last pixel, so the new count is
      // visible together with screenEnd.
      if (pixEn && w_dispIn.isEnd) begin
        r_frameCount <= r_frameCount + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fetchActive = r_stage[0].active;
  assign fetchX      = r_stage[0].x;
  assign fetchY      = r_stage[0].y;

  assign active      = r_stage[LEAD].active;
  assign x           = r_stage[LEAD].x;
  assign y           = r_stage[LEAD].y;
  assign hSync       = r_stage[LEAD].hWin ? c_H_POL : ~c_H_POL;
  assign vSync       = r_stage[LEAD].vWin ? c_V_POL : ~c_V_POL;
  assign lineStart   = r_stage[LEAD].isLineStart  & r_pixTick;
  assign frameStart  = r_stage[LEAD].isFrameStart & r_pixTick;
  assign screenEnd   = r_stage[LEAD].isEnd        & r_pixTick;
  assign frameCount  = r_frameCount;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_engine
// Purpose  : Self-checking bench for vga_timing_engine. The small raster is
//            H 8/2/3/3 and V 4/1/2/1. Instance A uses LEAD=2 with negative
//            syncs. Instance B uses LEAD=0 with positive syncs. Expected
//            outputs come from the pixel-tick count since reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_engine;

  localparam int HT = 16;
  localparam int VT = 8;
  localparam int FT = HT * VT;
  localparam int LA = 2;
  localparam int LB = 0;

  logic clk25 = 1'b0;
  logic reset = 1'b1;
  logic pixEn = 1'b0;

  logic       aFetchActive, aActive, aHSync, aVSync, aLineStart, aFrameStart, aScreenEnd;
  logic [3:0] aFetchX, aX;
  logic [2:0] aFetchY, aY;
  logic [15:0] aFrameCount;
  logic       bFetchActive, bActive, bHSync, bVSync, bLineStart, bFrameStart, bScreenEnd;
  logic [3:0] bFetchX, bX;
  logic [2:0] bFetchY, bY;
  logic [15:0] bFrameCount;

  vga_timing_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(0), .V_POL(0), .LEAD(LA), .XW(4), .YW(3)
  ) dutA (
    .clk25(clk25), .reset(reset), .pixEn(pixEn),
    .fetchActive(aFetchActive), .fetchX(aFetchX), .fetchY(aFetchY),
    .active(aActive), .x(aX), .y(aY), .hSync(aHSync), .vSync(aVSync),
    .lineStart(aLineStart), .frameStart(aFrameStart), .screenEnd(aScreenEnd),
    .frameCount(aFrameCount)
  );

  vga_timing_engine #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1), .V_POL(1), .LEAD(LB), .XW(4), .YW(3)
  ) dutB (
    .clk25(clk25), .reset(reset), .pixEn(pixEn),
    .fetchActive(bFetchActive), .fetchX(bFetchX), .fetchY(bFetchY),
    .active(bActive), .x(bX), .y(bY), .hSync(bHSync), .vSync(bVSync),
    .lineStart(bLineStart), .frameStart(bFrameStart), .screenEnd(bScreenEnd),
    .frameCount(bFrameCount)
  );

  always #5 clk25 = ~clk25;

  int nVec = 0;
  int nMis = 0;

  // Reference state: pixel ticks since reset and whether the last edge ticked.
  int k        = 0;
  bit lastTick = 1'b0;
  int adjA     = 0;   // frame-count offset introduced by the forced value
  bit chkOn    = 1'b0;

  always @(posedge clk25) begin
    if (reset) begin
      k        = 0;
      lastTick = 1'b0;
    end else if (pixEn) begin
      k        = k + 1;
      lastTick = 1'b1;
    end else begin
      lastTick = 1'b0;
    end
  end

  // Expected outputs after kk ticks: the fetch stream shows raster position
  // kk-1 and the display stream shows raster position kk-1-lead.
  function automatic logic [36:0] expOut(int kk, bit lt, int lead, bit hp, bit vp, int adj);
    int p, h, v, d, n;
    logic fa, da, hs, vs, ls, fs, se;
    logic [3:0] fx, dx;
    logic [2:0] fy, dy;
    logic [15:0] fc;
    fa = 0; fx = 0; fy = 0; da = 0; dx = 0; dy = 0;
    hs = ~hp; vs = ~vp; ls = 0; fs = 0; se = 0;
    if (kk >= 1) begin
      p = (kk - 1) % FT; h = p % HT; v = p / HT;
      if (h < 8 && v < 4) begin fa = 1; fx = 4'(h); fy = 3'(v); end
    end
    d = kk - 1 - lead;
    if (d >= 0) begin
      p = d % FT; h = p % HT; v = p / HT;
      if (h < 8 && v < 4) begin da = 1; dx = 4'(h); dy = 3'(v); end
      if (h >= 10 && h < 13) hs = hp;
      if (v >= 5 && v < 7) vs = vp;
      ls = lt && (h == 0);
      fs = lt && (h == 0) && (v == 0);
      se = lt && (h == 15) && (v == 7);
    end
    n  = (kk - lead > 0) ? (kk - lead) / FT : 0;
    fc = 16'(n + adj);
    return {fa, fx, fy, da, dx, dy, hs, vs, ls, fs, se, fc};
  endfunction

  task automatic chk(string name, longint act, longint req);
    nVec++;
    if (act != req) begin
      nMis++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic checkCycle();
    logic [36:0] actA, actB;
    if (chkOn) begin
      actA = {aFetchActive, aFetchX, aFetchY, aActive, aX, aY, aHSync, aVSync,
              aLineStart, aFrameStart, aScreenEnd, aFrameCount};
      actB = {bFetchActive, bFetchX, bFetchY, bActive, bX, bY, bHSync, bVSync,
              bLineStart, bFrameStart, bScreenEnd, bFrameCount};
      chk("model dutA", longint'(actA), longint'(expOut(k, lastTick, LA, 1'b0, 1'b0, adjA)));
      chk("model dutB", longint'(actB), longint'(expOut(k, lastTick, LB, 1'b1, 1'b1, 0)));
    end
  endtask

  // One clock: check the model at the falling edge, drive inputs, then let
  // the rising edge happen and return 1 time unit after it.
  task automatic step(bit r, bit p);
    @(negedge clk25);
    checkCycle();
    reset = r;
    pixEn = p;
    @(posedge clk25);
    #1;
  endtask

  typedef struct {
    int rst, pe;
    int fa, fx, fy;
    int da, dx, dy, ls, fs, hs;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int fs1, fs2, nHs, nVs, nAct, nXBad, nLs, nBHs;
    int fsCnt, fsWide, holdBad, firstFetch, fsA, fsB;
    int prevFc, seIdx;
    logic [32:0] prevVec, curVec;
    bit prevFs, p;

    // rst pe | fa fx fy | da dx dy ls fs hs
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[2]  = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 1, 1, 2, 0, 1, 0, 0, 1, 1, 1};
    tbl[4]  = '{0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 1, 2, 0, 1, 0, 0, 0, 0, 1};
    tbl[6]  = '{0, 1, 1, 3, 0, 1, 1, 0, 0, 0, 1};
    tbl[7]  = '{0, 1, 1, 4, 0, 1, 2, 0, 0, 0, 1};
    tbl[8]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[10] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};

    reset = 1'b1; pixEn = 1'b0;
    repeat (2) @(posedge clk25);
    #1;
    chkOn = 1'b1;

    // ---------------- table-driven reset release / hold vectors ----------------
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].rst[0], tbl[i].pe[0]);
      chk($sformatf("tbl%0d fetch", i), longint'({aFetchActive, aFetchX, aFetchY}),
          longint'((tbl[i].fa << 7) | (tbl[i].fx << 3) | tbl[i].fy));
      chk($sformatf("tbl%0d display", i),
          longint'({aActive, aX, aY, aLineStart, aFrameStart, aHSync}),
          longint'((tbl[i].da << 10) | (tbl[i].dx << 6) | (tbl[i].dy << 3) |
                   (tbl[i].ls << 2) | (tbl[i].fs << 1) | tbl[i].hs));
      if (i == 0) chk("tbl0 dutB reset syncs", longint'({bHSync, bVSync}), 0);
    end

    // ---------------- reset release and one full frame ----------------
    step(1'b1, 1'b1);
    fs1 = -1; fs2 = -1; nHs = 0; nVs = 0; nAct = 0; nXBad = 0; nLs = 0; nBHs = 0;
    for (int i = 1; i <= 300; i++) begin
      step(1'b0, 1'b1);
      if (aFrameStart) begin
        if (fs1 < 0) fs1 = i;
        else if (fs2 < 0) fs2 = i;
      end
      if (fs1 > 0 && i < fs1 + FT) begin
        if (!aHSync) nHs++;
        if (!aVSync) nVs++;
        if (aActive) nAct++;
        if (aLineStart) nLs++;
        if (bHSync) nBHs++;
        if (((i - fs1) % HT) >= 8 && aX != 4'd0) nXBad++;
      end
    end
    chk("first frameStart edge", fs1, 3);
    chk("frameStart period", fs2 - fs1, FT);
    chk("hSync low cycles per frame", nHs, 24);
    chk("vSync low cycles per frame", nVs, 32);
    chk("active cycles per frame", nAct, 32);
    chk("lineStart per frame", nLs, 8);
    chk("x nonzero in blanking", nXBad, 0);
    chk("dutB hSync high per frame", nBHs, 24);

    // ---------------- pixEn pattern 1,0,0 ----------------
    step(1'b1, 1'b1);
    fsA = -1; fsB = -1; fsCnt = 0; fsWide = 0; holdBad = 0; firstFetch = -1;
    prevFs = 1'b0; prevVec = '0;
    for (int i = 1; i <= 1200; i++) begin
      p = (i % 3 == 1);
      step(1'b0, p);
      curVec = {aFetchActive, aFetchX, aFetchY, aActive, aX, aY, aHSync, aVSync, aFrameCount};
      if (!p && (curVec != prevVec || aLineStart || aFrameStart || aScreenEnd)) holdBad++;
      if (firstFetch < 0 && aFetchActive && aFetchX == 4'd0 && aFetchY == 3'd0) firstFetch = i;
      if (aFrameStart) begin
        fsCnt++;
        if (prevFs) fsWide++;
        if (fsA < 0) fsA = i;
        else if (fsB < 0) fsB = i;
      end
      prevFs  = aFrameStart;
      prevVec = curVec;
    end
    chk("stalled frame span", fsB - fsA, 3 * FT);
    chk("stalled fetch lead", fsA - firstFetch, 6);
    chk("outputs held while stalled", holdBad, 0);
    chk("frameStart count stalled", fsCnt, 4);
    chk("frameStart wider than 1", fsWide, 0);

    // ---------------- reset asserted at display (5,2) ----------------
    step(1'b1, 1'b1);
    seIdx = -1;
    for (int i = 1; i <= 400; i++) begin
      step(1'b0, 1'b1);
      if (i > FT + 10 && aActive && aX == 4'd5 && aY == 3'd2) begin
        seIdx = i;
        break;
      end
    end
    chk("reached display (5,2)", longint'(seIdx > 0), 1);
    chk("frameCount before mid reset", aFrameCount, 1);
    step(1'b1, 1'b1);
    chk("mid reset display", longint'({aActive, aX, aY, aHSync, aVSync}), longint'(9'b0_0000_000_11));
    chk("mid reset frameCount", aFrameCount, 0);
    chk("mid reset dutB syncs", longint'({bHSync, bVSync}), 0);
    fs1 = -1; firstFetch = -1;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 1'b1);
      if (firstFetch < 0 && aFetchActive && aFetchX == 4'd0 && aFetchY == 3'd0) firstFetch = i;
      if (fs1 < 0 && aFrameStart) fs1 = i;
    end
    chk("restart fetch edge", firstFetch, 1);
    chk("restart frameStart edge", fs1, 3);

    // ---------------- first-frame counter ----------------
    step(1'b1, 1'b1);
    seIdx = -1; prevFc = -1;
    for (int i = 1; i <= 200; i++) begin
      step(1'b0, 1'b1);
      if (aScreenEnd) begin
        seIdx = i;
        chk("frameCount before first end", prevFc, 0);
        chk("frameCount at first end", aFrameCount, 1);
        break;
      end
      prevFc = aFrameCount;
    end
    chk("first screenEnd edge", seIdx, FT + 2);

    // ---------------- randomized pixEn with occasional reset ----------------
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0);
    end

    // ---------------- frame counter wrap ----------------
    step(1'b1, 1'b1);
    for (int i = 0; i < 200; i++) step(1'b0, 1'b1);
    seIdx = -1;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1);
      if (aActive && aY == 3'd1) begin seIdx = i; break; end
    end
    chk("reached row 1 before force", longint'(seIdx >= 0), 1);
    force dutA.r_frameCount = 16'hFFFF;
    adjA = 16'hFFFF - ((k - LA > 0) ? (k - LA) / FT : 0);
    step(1'b0, 1'b1);
    release dutA.r_frameCount;
    seIdx = -1;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1);
      if (aScreenEnd) begin seIdx = i; break; end
      chk("frameCount held at 0xFFFF", aFrameCount, 16'hFFFF);
    end
    chk("screenEnd after force", longint'(seIdx >= 0), 1);
    chk("frameCount wrapped", aFrameCount, 0);
    chk("syncs at wrap", longint'({aHSync, aVSync}), 3);
    step(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
`default_nettype wire
